// File: rtl/arf_commit_sched.sv
// Retire-side ARF write sequencer: in-order commit queue, dual-port drain,
// same-register collision squash, p0 filtering, flush and drain hold.
module arf_commit_sched #(
   parameter int AR_SIZE = 6,
   parameter int DATA_W  = 32,
   parameter int QDEPTH  = 8
) (
   input  logic                         clk,
   input  logic                         rstn,
   input  logic                         flush,
   input  logic                         drain_en,
   input  logic [1:0]                   rt_valid,
   input  logic [AR_SIZE-1:0]           rt_addr0,
   input  logic [AR_SIZE-1:0]           rt_addr1,
   input  logic [AR_SIZE-1:0]           rt_old0,
   input  logic [AR_SIZE-1:0]           rt_old1,
   input  logic [DATA_W-1:0]            rt_data0,
   input  logic [DATA_W-1:0]            rt_data1,
   output logic                         rt_ready,
   output logic [AR_SIZE-1:0]           wr_addr1,
   output logic [AR_SIZE-1:0]           wr_addr2,
   output logic [AR_SIZE-1:0]           wr_old1,
   output logic [AR_SIZE-1:0]           wr_old2,
   output logic [DATA_W-1:0]            wr_data1,
   output logic [DATA_W-1:0]            wr_data2,
   output logic                         wr_en,
   output logic [$clog2(QDEPTH):0]      q_count,
   output logic                         q_empty,
   output logic [31:0]                  commit_cnt
);

   localparam int PW = $clog2(QDEPTH);
   localparam int CW = PW + 1;

   logic [AR_SIZE-1:0] addr_mem [QDEPTH];
   logic [AR_SIZE-1:0] old_mem  [QDEPTH];
   logic [DATA_W-1:0]  data_mem [QDEPTH];

   logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [31:0]        commit_q, commit_d;

   logic               wr_en_q, wr_en_d;
   logic [AR_SIZE-1:0] wr_addr1_q, wr_addr1_d;
   logic [AR_SIZE-1:0] wr_addr2_q, wr_addr2_d;
   logic [AR_SIZE-1:0] wr_old1_q, wr_old1_d;
   logic [AR_SIZE-1:0] wr_old2_q, wr_old2_d;
   logic [DATA_W-1:0]  wr_data1_q, wr_data1_d;
   logic [DATA_W-1:0]  wr_data2_q, wr_data2_d;

   logic               push0, push1;
   logic               do_push, do_pop, two_pop, coll;
   logic               we0, we1;
   logic [CW-1:0]      n_push, n_pop;
   logic [PW-1:0]      rd1, wp1;
   logic [AR_SIZE-1:0] e0_addr, e1_addr, e0_old, e1_old;
   logic [DATA_W-1:0]  e0_data, e1_data;
   logic [AR_SIZE-1:0] f_addr, f_old;
   logic [DATA_W-1:0]  f_data;

   // Room for a full retire pair depends only on the registered count.
   assign rt_ready = (cnt_q <= CW'(QDEPTH - 2));

   // Push/pop decisions, pointer/count update and next registered outputs.
   always_comb begin
      push0   = rt_valid[0] && (rt_addr0 != '0);
      push1   = rt_valid[1] && (rt_addr1 != '0);
      do_push = rt_ready && !flush;
      do_pop  = drain_en && !flush && (cnt_q != '0);
      two_pop = (cnt_q >= CW'(2));
      rd1     = rd_ptr_q + PW'(1);
      wp1     = wr_ptr_q + PW'(1);

      e0_addr = addr_mem[rd_ptr_q];
      e0_old  = old_mem[rd_ptr_q];
      e0_data = data_mem[rd_ptr_q];
      e1_addr = addr_mem[rd1];
      e1_old  = old_mem[rd1];
      e1_data = data_mem[rd1];
      coll    = two_pop && (e0_addr == e1_addr);

      // slot1 alone is compacted into the first free entry
      f_addr  = push0 ? rt_addr0 : rt_addr1;
      f_old   = push0 ? rt_old0  : rt_old1;
      f_data  = push0 ? rt_data0 : rt_data1;
      we0     = do_push && (push0 || push1);
      we1     = do_push && push0 && push1;

      n_push  = '0;
      if (do_push)
         n_push = CW'(push0) + CW'(push1);
      n_pop   = '0;
      if (do_pop)
         n_pop = two_pop ? CW'(2) : CW'(1);

      wr_ptr_d = wr_ptr_q + n_push[PW-1:0];
      rd_ptr_d = rd_ptr_q + n_pop[PW-1:0];
      cnt_d    = cnt_q + n_push - n_pop;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
      end

      wr_en_d    = do_pop;
      wr_addr1_d = '0;
      wr_addr2_d = '0;
      wr_old1_d  = wr_old1_q;
      wr_old2_d  = wr_old2_q;
      wr_data1_d = wr_data1_q;
      wr_data2_d = wr_data2_q;
      if (do_pop) begin
         wr_addr1_d = coll ? '0 : e0_addr;
         wr_old1_d  = e0_old;
         wr_data1_d = e0_data;
         wr_addr2_d = two_pop ? e1_addr : '0;
         wr_old2_d  = two_pop ? e1_old  : '0;
         wr_data2_d = two_pop ? e1_data : '0;
      end

      commit_d = commit_q
               + 32'(wr_addr1_d != '0)
               + 32'(wr_addr2_d != '0);
   end

   // Queue storage; contents need no reset since count gates every read.
   always_ff @(posedge clk) begin
      if (we0) begin
         addr_mem[wr_ptr_q] <= f_addr;
         old_mem[wr_ptr_q]  <= f_old;
         data_mem[wr_ptr_q] <= f_data;
      end
      if (we1) begin
         addr_mem[wp1] <= rt_addr1;
         old_mem[wp1]  <= rt_old1;
         data_mem[wp1] <= rt_data1;
      end
   end

   // Pointers, occupancy, counters and registered ARF write outputs.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         cnt_q      <= '0;
         commit_q   <= '0;
         wr_en_q    <= 1'b0;
         wr_addr1_q <= '0;
         wr_addr2_q <= '0;
         wr_old1_q  <= '0;
         wr_old2_q  <= '0;
         wr_data1_q <= '0;
         wr_data2_q <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         cnt_q      <= cnt_d;
         commit_q   <= commit_d;
         wr_en_q    <= wr_en_d;
         wr_addr1_q <= wr_addr1_d;
         wr_addr2_q <= wr_addr2_d;
         wr_old1_q  <= wr_old1_d;
         wr_old2_q  <= wr_old2_d;
         wr_data1_q <= wr_data1_d;
         wr_data2_q <= wr_data2_d;
      end
   end

`ifndef SYNTHESIS
   // Occupancy can never exceed the queue depth.
   always_ff @(posedge clk) begin
      if (rstn)
         assert (cnt_q <= CW'(QDEPTH));
   end
`endif

   assign wr_en      = wr_en_q;
   assign wr_addr1   = wr_addr1_q;
   assign wr_addr2   = wr_addr2_q;
   assign wr_old1    = wr_old1_q;
   assign wr_old2    = wr_old2_q;
   assign wr_data1   = wr_data1_q;
   assign wr_data2   = wr_data2_q;
   assign q_count    = cnt_q;
   assign q_empty    = (cnt_q == '0);
   assign commit_cnt = commit_q;

endmodule

// File: tb/tb_arf_commit_sched.sv
// Bench for arf_commit_sched: directed scenarios then random traffic,
// checked against a queue-based reference model.
module tb_arf_commit_sched;

   localparam int AR = 6;
   localparam int DW = 32;
   localparam int QD = 8;

   typedef struct {
      logic [AR-1:0] addr;
      logic [AR-1:0] old;
      logic [DW-1:0] data;
   } ent_t;

   logic          clk = 1'b0;
   logic          rstn;
   logic          flush;
   logic          drain_en;
   logic [1:0]    rt_valid;
   logic [AR-1:0] rt_addr0, rt_addr1, rt_old0, rt_old1;
   logic [DW-1:0] rt_data0, rt_data1;
   logic          rt_ready;
   logic [AR-1:0] wr_addr1, wr_addr2, wr_old1, wr_old2;
   logic [DW-1:0] wr_data1, wr_data2;
   logic          wr_en;
   logic [3:0]    q_count;
   logic          q_empty;
   logic [31:0]   commit_cnt;

   int total = 0;
   int bad   = 0;

   ent_t          mq[$];
   logic [31:0]   m_cnt;
   logic          e_en;
   logic [AR-1:0] e_a1, e_a2, e_o1, e_o2;
   logic [DW-1:0] e_d1, e_d2;

   always #5 clk = ~clk;

   arf_commit_sched #(.AR_SIZE(AR), .DATA_W(DW), .QDEPTH(QD)) dut (
      .clk(clk), .rstn(rstn), .flush(flush), .drain_en(drain_en),
      .rt_valid(rt_valid),
      .rt_addr0(rt_addr0), .rt_addr1(rt_addr1),
      .rt_old0(rt_old0), .rt_old1(rt_old1),
      .rt_data0(rt_data0), .rt_data1(rt_data1),
      .rt_ready(rt_ready),
      .wr_addr1(wr_addr1), .wr_addr2(wr_addr2),
      .wr_old1(wr_old1), .wr_old2(wr_old2),
      .wr_data1(wr_data1), .wr_data2(wr_data2),
      .wr_en(wr_en), .q_count(q_count), .q_empty(q_empty),
      .commit_cnt(commit_cnt)
   );

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_cnt = 0;
      e_en = 0;
      e_a1 = 0; e_a2 = 0; e_o1 = 0; e_o2 = 0;
      e_d1 = 0; e_d2 = 0;
   endtask

   task automatic chk_outs(input string tag);
      chk({tag, "_en"}, 64'(wr_en), 64'(e_en));
      chk({tag, "_a1"}, 64'(wr_addr1), 64'(e_a1));
      chk({tag, "_a2"}, 64'(wr_addr2), 64'(e_a2));
      chk({tag, "_o1"}, 64'(wr_old1), 64'(e_o1));
      chk({tag, "_o2"}, 64'(wr_old2), 64'(e_o2));
      chk({tag, "_d1"}, 64'(wr_data1), 64'(e_d1));
      chk({tag, "_d2"}, 64'(wr_data2), 64'(e_d2));
      chk({tag, "_cc"}, 64'(commit_cnt), 64'(m_cnt));
      chk({tag, "_qc"}, 64'(q_count), 64'(mq.size()));
      chk({tag, "_qe"}, 64'(q_empty), 64'(mq.size() == 0));
      chk({tag, "_rdy"}, 64'(rt_ready), 64'((QD - mq.size()) >= 2));
   endtask

   // One clock: drive inputs, advance the model, check after the edge.
   task automatic cyc(input string tag, input bit fl, input bit dr,
                      input bit [1:0] v,
                      input bit [AR-1:0] a0, input bit [AR-1:0] a1,
                      input bit [DW-1:0] d0, input bit [DW-1:0] d1);
      bit   ready;
      int   n;
      ent_t p0, p1;
      flush    = fl;
      drain_en = dr;
      rt_valid = v;
      rt_addr0 = a0;
      rt_addr1 = a1;
      rt_old0  = AR'($urandom);
      rt_old1  = AR'($urandom);
      rt_data0 = d0;
      rt_data1 = d1;
      ready = (QD - mq.size()) >= 2;
      chk({tag, "_prerdy"}, 64'(rt_ready), 64'(ready));
      if (fl) begin
         mq.delete();
         e_en = 0; e_a1 = 0; e_a2 = 0;
      end else begin
         if (dr && mq.size() > 0) begin
            n = (mq.size() >= 2) ? 2 : 1;
            p0 = mq.pop_front();
            e_en = 1;
            e_o1 = p0.old;
            e_d1 = p0.data;
            e_a1 = p0.addr;
            if (n == 2) begin
               p1 = mq.pop_front();
               if (p1.addr == p0.addr) e_a1 = 0;
               e_a2 = p1.addr; e_o2 = p1.old; e_d2 = p1.data;
            end else begin
               e_a2 = 0; e_o2 = 0; e_d2 = 0;
            end
            m_cnt = m_cnt + 32'(e_a1 != 0) + 32'(e_a2 != 0);
         end else begin
            e_en = 0; e_a1 = 0; e_a2 = 0;
         end
         if (ready) begin
            if (v[0] && a0 != 0)
               mq.push_back('{addr: a0, old: rt_old0, data: d0});
            if (v[1] && a1 != 0)
               mq.push_back('{addr: a1, old: rt_old1, data: d1});
         end
      end
      @(posedge clk);
      #1;
      chk_outs(tag);
   endtask

   task automatic idle(input string tag);
      cyc(tag, 0, 1, 2'b00, 0, 0, 0, 0);
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      flush = 0; drain_en = 0; rt_valid = 0;
      rt_addr0 = 0; rt_addr1 = 0; rt_old0 = 0; rt_old1 = 0;
      rt_data0 = 0; rt_data1 = 0;
      model_reset();
      #2;
      chk_outs("rst");
      @(negedge clk);
      rstn = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] base;
      bit [AR-1:0] a0, a1;
      rstn = 1'b1;
      #3;
      do_reset();

      // 1: basic pair
      cyc("t1p", 0, 1, 2'b11, 5, 6, 10, 20);
      chk("t1_en_pre", 64'(wr_en), 64'd0);
      idle("t1w");
      chk("t1_a1", 64'(wr_addr1), 64'd5);
      chk("t1_d1", 64'(wr_data1), 64'd10);
      chk("t1_a2", 64'(wr_addr2), 64'd6);
      chk("t1_d2", 64'(wr_data2), 64'd20);
      chk("t1_cc", 64'(commit_cnt), 64'd2);
      idle("t1i");

      // 2: hold, fill, ignored push, drain
      for (int i = 0; i < 4; i++)
         cyc("t2f", 0, 0, 2'b11, AR'(10 + 2 * i), AR'(11 + 2 * i),
             32'(100 + i), 32'(200 + i));
      chk("t2_qc", 64'(q_count), 64'd8);
      chk("t2_rdy", 64'(rt_ready), 64'd0);
      cyc("t2x", 0, 0, 2'b11, 30, 31, 99, 98);
      chk("t2_qc5", 64'(q_count), 64'd8);
      for (int i = 0; i < 4; i++) begin
         cyc("t2d", 0, 1, 2'b00, 0, 0, 0, 0);
         chk("t2_ord", 64'(wr_addr1), 64'(10 + 2 * i));
      end
      chk("t2_qe", 64'(q_empty), 64'd1);
      idle("t2i");

      // 3: collision
      base = m_cnt;
      cyc("t3p", 0, 1, 2'b11, 7, 7, 1, 2);
      idle("t3w");
      chk("t3_a1", 64'(wr_addr1), 64'd0);
      chk("t3_a2", 64'(wr_addr2), 64'd7);
      chk("t3_d2", 64'(wr_data2), 64'd2);
      chk("t3_cc", 64'(commit_cnt - base), 64'd1);

      // 4: p0 slot dropped, slot1 compacted
      cyc("t4p", 0, 1, 2'b11, 0, 9, 3, 4);
      chk("t4_qc", 64'(q_count), 64'd1);
      idle("t4w");
      chk("t4_a1", 64'(wr_addr1), 64'd9);
      chk("t4_d1", 64'(wr_data1), 64'd4);
      chk("t4_a2", 64'(wr_addr2), 64'd0);
      chk("t4_d2", 64'(wr_data2), 64'd0);

      // 5: flush with five queued entries
      cyc("t5a", 0, 0, 2'b11, 11, 12, 1, 2);
      cyc("t5b", 0, 0, 2'b11, 13, 14, 3, 4);
      cyc("t5c", 0, 0, 2'b01, 15, 16, 5, 6);
      chk("t5_qc", 64'(q_count), 64'd5);
      cyc("t5f", 1, 1, 2'b11, 17, 18, 7, 8);
      chk("t5_en", 64'(wr_en), 64'd0);
      chk("t5_q0", 64'(q_count), 64'd0);
      chk("t5_rdy", 64'(rt_ready), 64'd1);
      idle("t5i");

      // 6: streaming with pointer wrap
      base = m_cnt;
      for (int i = 0; i < 3 * QD; i++) begin
         a0 = AR'((2 * i) % 62 + 1);
         a1 = a0 + 1;
         cyc("t6s", 0, 1, 2'b11, a0, a1, $urandom, $urandom);
      end
      idle("t6d");
      chk("t6_cc", 64'(commit_cnt - base), 64'(6 * QD));
      chk("t6_qe", 64'(q_empty), 64'd1);

      // random traffic with a mid-run reset
      for (int i = 0; i < 400; i++) begin
         if (i == 200) do_reset();
         cyc("rnd", ($urandom_range(0, 19) == 0),
             ($urandom_range(0, 3) != 0),
             2'($urandom),
             AR'($urandom_range(0, 7)), AR'($urandom_range(0, 7)),
             $urandom, $urandom);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
